// File: rtl/xg_mem_arbiter.sv
// xg_mem_arbiter: shares one single-port fixed-latency memory between the IF
// and MEM stages. One transaction outstanding at a time; the response is
// registered and pulsed back to the owning stage MEM_LAT+1 cycles after grant.
// Optional feature: define ARB_RR_EN to alternate contested grants between
// fetch and data; otherwise data always wins when both request.
module xg_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  m_req,
    output logic                  m_we,
    output logic [DATA_W/8-1:0]   m_be,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic [DATA_W-1:0]     m_rdata,
    output logic                  stallF,
    output logic                  stallM
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    if (MEM_LAT < 1) begin : g_lat_check
        $error("xg_mem_arbiter: MEM_LAT must be >= 1");
    end

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              store_q, store_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
`ifdef ARB_RR_EN
    logic              last_win_q, last_win_d;
`endif

    logic if_pend, d_pend, grant_if, grant_d;

    // A request still high during its own rvalid cycle is the completed one,
    // not a new one, so it is masked out of arbitration for that cycle.
    assign if_pend = if_req & ~if_rvalid_q;
    assign d_pend  = d_req  & ~d_rvalid_q;

    // Pick the winner in IDLE and drive its command onto the memory port.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (!reset && state_q == ST_IDLE) begin
`ifdef ARB_RR_EN
            if (if_pend && d_pend) begin
                grant_d  = (last_win_q == OWN_IF);
                grant_if = (last_win_q == OWN_D);
            end else begin
                grant_d  = d_pend;
                grant_if = if_pend;
            end
`else
            grant_d  = d_pend;
            grant_if = if_pend & ~d_pend;
`endif
        end
        m_req   = grant_if | grant_d;
        m_we    = grant_d & d_we;
        m_be    = grant_d ? d_be : '0;
        m_addr  = grant_d ? d_addr : (grant_if ? if_addr : '0);
        m_wdata = grant_d ? d_wdata : '0;
    end

    // Transaction sequencing: latch owner on issue, count down, return data.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        store_d     = store_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
`ifdef ARB_RR_EN
        last_win_d  = last_win_q;
`endif
        if (state_q == ST_IDLE) begin
            if (grant_if || grant_d) begin
                state_d = ST_BUSY;
                cnt_d   = CNT_INIT;
                owner_d = grant_d ? OWN_D : OWN_IF;
                store_d = grant_d & d_we;
`ifdef ARB_RR_EN
                if (if_pend && d_pend) begin
                    last_win_d = grant_d ? OWN_D : OWN_IF;
                end
`endif
            end
        end else begin
            if (cnt_q == '0) begin
                state_d = ST_IDLE;
                if (owner_q == OWN_D) begin
                    d_rvalid_d = 1'b1;
                    if (!store_q) begin
                        d_rdata_d = m_rdata;
                    end
                end else begin
                    if_rvalid_d = 1'b1;
                    if_rdata_d  = m_rdata;
                end
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset; reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            owner_q     <= OWN_IF;
            store_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
`ifdef ARB_RR_EN
            last_win_q  <= OWN_IF;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            store_q     <= store_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
`ifdef ARB_RR_EN
            last_win_q  <= last_win_d;
`endif
        end
    end

    assign if_gnt    = grant_if;
    assign d_gnt     = grant_d;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign stallF    = ~reset & if_req & ~if_rvalid_q;
    assign stallM    = ~reset & d_req & ~d_rvalid_q;

endmodule

// File: tb/tb_xg_mem_arbiter.sv
// Bench for xg_mem_arbiter: table vectors, directed multi-cycle sequences and
// a randomized phase checked against a transaction-level reference model.
module tb_xg_mem_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
    logic [31:0] if_rdata, d_rdata;
    logic        m_req, m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata = 32'hDEAD_BEEF;
    logic        stallF, stallM;

    xg_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata),
        .stallF(stallF), .stallM(stallM)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    logic [31:0] mem    [bit [31:0]];
    logic [31:0] shadow [bit [31:0]];

    typedef struct { int unsigned due; logic [31:0] addr; } rd_t;
    rd_t rdq[$];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] shadow_read(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : init_word(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                          input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Memory responder: writes on issue, read data valid exactly LAT cycles later.
    always @(negedge clk) begin
        if (m_req) begin
            if (m_we) mem[m_addr] = merge(mem_read(m_addr), m_be, m_wdata);
            else      rdq.push_back(rd_t'{cyc + LAT, m_addr});
        end
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        while (rdq.size() > 0 && rdq[0].due < cyc) void'(rdq.pop_front());
        if (rdq.size() > 0 && rdq[0].due == cyc) begin
            m_rdata = mem_read(rdq[0].addr);
            void'(rdq.pop_front());
        end else begin
            m_rdata = 32'hDEAD_BEEF;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; d_req = 0; d_we = 0; d_be = '0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic do_reset(input int n);
        reset = 1;
        idle_inputs();
        repeat (n) step();
        reset = 0;
    endtask

    task automatic data_xact(input logic we, input logic [3:0] be, input logic [31:0] addr,
                             input logic [31:0] wd, output int gnt_at, output int rv_at,
                             output logic [31:0] rd);
        d_req = 1; d_we = we; d_be = be; d_addr = addr; d_wdata = wd;
        gnt_at = -1; rv_at = -1; rd = '0;
        for (int c = 0; c < 10 && rv_at < 0; c++) begin
            if (c > 0) step();
            @(negedge clk);
            if (d_gnt && gnt_at < 0) gnt_at = c;
            if (d_rvalid) begin rv_at = c; rd = d_rdata; end
        end
        step();
        idle_inputs();
    endtask

    task automatic contest(input logic [31:0] ia, input logic [31:0] da, output logic first_d);
        logic got_first, i_done, d_done;
        if_req = 1; if_addr = ia; d_req = 1; d_we = 0; d_addr = da; d_be = 4'hF;
        first_d = 0; got_first = 0; i_done = 0; d_done = 0;
        for (int c = 0; c < 12 && !(i_done && d_done); c++) begin
            if (c > 0) begin
                step();
                if (d_done) d_req = 0;
                if (i_done) if_req = 0;
            end
            @(negedge clk);
            if (!got_first && (if_gnt || d_gnt)) begin got_first = 1; first_d = d_gnt; end
            if (d_rvalid) d_done = 1;
            if (if_rvalid) i_done = 1;
        end
        check("contest_done", {62'd0, i_done, d_done}, 64'd3);
        step();
        idle_inputs();
    endtask

    typedef struct {
        string       name;
        logic        if_req, d_req, d_we;
        logic [3:0]  d_be;
        logic [31:0] if_addr, d_addr, d_wdata;
        logic        e_if_gnt, e_d_gnt, e_m_we;
        logic [3:0]  e_m_be;
        logic [31:0] e_m_addr, e_m_wdata;
    } vec_t;

    // Random-phase agent state
    logic        i_active, i_granted, i_got, d_active, d_granted, d_got, d_store;
    int          i_gnt_n, d_gnt_n, i_gap, d_gap;
    logic [31:0] i_exp, d_exp, d_model_rdata;
    logic        ref_last_d;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[6];
        logic [3:0]  ig4, iv4, sf4;
        logic [6:0]  dg7, dv7, ig7, iv7, sf7;
        logic [4:0]  dv5;
        logic [31:0] rd, rd2;
        int          g, r;
        logic        fd, rst_rv, rst_mreq;
        logic        i_pend, d_pend, busy, exp_any, exp_d, exp_iv, exp_dv;

        vecs[0] = '{"none",    0,0,0,4'h0,32'h140,32'h2020,32'h0,       0,0,0,4'h0,32'h0,   32'h0};
        vecs[1] = '{"fetch",   1,0,0,4'h0,32'h140,32'h2020,32'h0,       1,0,0,4'h0,32'h140, 32'h0};
        vecs[2] = '{"load",    0,1,0,4'hF,32'h140,32'h2020,32'h0,       0,1,0,4'hF,32'h2020,32'h0};
        vecs[3] = '{"store",   0,1,1,4'h5,32'h140,32'h2024,32'h11223344,0,1,1,4'h5,32'h2024,32'h11223344};
        vecs[4] = '{"both_st", 1,1,1,4'hC,32'h144,32'h2028,32'hCAFE0000,0,1,1,4'hC,32'h2028,32'hCAFE0000};
        vecs[5] = '{"both_ld", 1,1,0,4'hF,32'h148,32'h202C,32'h0,       0,1,0,4'hF,32'h202C,32'h0};

        mem[32'h100]    = 32'h00500093;
        shadow[32'h100] = 32'h00500093;

        // Reset held 3 cycles with both requests high
        idle_inputs();
        reset = 1; if_req = 1; d_req = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            check("reset_ctrl", {57'd0, if_gnt, d_gnt, m_req, if_rvalid, d_rvalid, stallF, stallM}, 64'd0);
            check("reset_rdata", {if_rdata, d_rdata}, 64'd0);
            check("reset_maddr", {32'd0, m_addr}, 64'd0);
        end
        step();
        reset = 0;
        idle_inputs();

        // Table vectors: issue behaviour from IDLE
        for (int i = 0; i < 6; i++) begin
            do_reset(1);
            if_req = vecs[i].if_req; d_req = vecs[i].d_req; d_we = vecs[i].d_we;
            d_be = vecs[i].d_be; if_addr = vecs[i].if_addr; d_addr = vecs[i].d_addr;
            d_wdata = vecs[i].d_wdata;
            if (vecs[i].d_req && vecs[i].d_we)
                shadow[vecs[i].d_addr] = merge(shadow_read(vecs[i].d_addr), vecs[i].d_be, vecs[i].d_wdata);
            @(negedge clk);
            check($sformatf("%s_gnt", vecs[i].name), {61'd0, if_gnt, d_gnt, m_req},
                  {61'd0, vecs[i].e_if_gnt, vecs[i].e_d_gnt, vecs[i].e_if_gnt | vecs[i].e_d_gnt});
            check($sformatf("%s_we_be", vecs[i].name), {59'd0, m_we, m_be}, {59'd0, vecs[i].e_m_we, vecs[i].e_m_be});
            check($sformatf("%s_addr", vecs[i].name), {32'd0, m_addr}, {32'd0, vecs[i].e_m_addr});
            check($sformatf("%s_wdata", vecs[i].name), {32'd0, m_wdata}, {32'd0, vecs[i].e_m_wdata});
            step();
            idle_inputs();
            repeat (LAT + 1) step();
        end

        // Lone fetch
        do_reset(1);
        if_req = 1; if_addr = 32'h100; rd = '0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) step();
            @(negedge clk);
            ig4[c] = if_gnt; iv4[c] = if_rvalid; sf4[c] = stallF;
            if (if_rvalid) rd = if_rdata;
            if (c == 0) check("t2_maddr", {32'd0, m_addr}, 64'h100);
        end
        check("t2_if_gnt", {60'd0, ig4}, 64'b0001);
        check("t2_if_rvalid", {60'd0, iv4}, 64'b1000);
        check("t2_stallF", {60'd0, sf4}, 64'b0111);
        check("t2_if_rdata", {32'd0, rd}, 64'h00500093);
        step();
        idle_inputs();

        // Contested load + fetch after reset: data first
        do_reset(1);
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h2000; if_req = 1; if_addr = 32'h104;
        rd = '0; rd2 = '0;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) begin
                step();
                if (dv7[c-1]) d_req = 0;
                if (iv7[c-1]) if_req = 0;
            end
            @(negedge clk);
            dg7[c] = d_gnt; dv7[c] = d_rvalid; ig7[c] = if_gnt; iv7[c] = if_rvalid; sf7[c] = stallF;
            if (d_rvalid) rd = d_rdata;
            if (if_rvalid) rd2 = if_rdata;
        end
        check("t3_d_gnt", {57'd0, dg7}, 64'b0000001);
        check("t3_d_rvalid", {57'd0, dv7}, 64'b0001000);
        check("t3_if_gnt", {57'd0, ig7}, 64'b0001000);
        check("t3_if_rvalid", {57'd0, iv7}, 64'b1000000);
        check("t3_stallF", {57'd0, sf7}, 64'b0111111);
        check("t3_d_rdata", {32'd0, rd}, {32'd0, shadow_read(32'h2000)});
        check("t3_if_rdata", {32'd0, rd2}, {32'd0, shadow_read(32'h104)});
        step();
        idle_inputs();

        // Four consecutive contests
        do_reset(1);
        for (int k = 0; k < 4; k++) begin
            contest(32'h180 + 32'(4*k), 32'h2030 + 32'(4*k), fd);
`ifdef ARB_RR_EN
            check($sformatf("t4_first_d_%0d", k), {63'd0, fd}, {63'd0, (k % 2) == 0});
`else
            check($sformatf("t4_first_d_%0d", k), {63'd0, fd}, 64'd1);
`endif
        end

        // Store with partial byte enables
        do_reset(1);
        data_xact(1'b0, 4'hF, 32'h2008, 32'h0, g, r, rd);
        check("t5_ld_timing", {32'(g), 32'(r)}, {32'd0, 32'd3});
        check("t5_ld_data", {32'd0, rd}, {32'd0, shadow_read(32'h2008)});
        d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h2004; d_wdata = 32'h0000ABCD;
        shadow[32'h2004] = merge(shadow_read(32'h2004), 4'b0011, 32'h0000ABCD);
        rd2 = '0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) begin
                step();
                if (dv5[c-1]) idle_inputs();
            end
            @(negedge clk);
            dv5[c] = d_rvalid;
            if (d_rvalid) rd2 = d_rdata;
            if (c == 0) begin
                check("t5_st_cmd", {57'd0, d_gnt, m_req, m_we, m_be}, {57'd0, 3'b111, 4'b0011});
                check("t5_st_addr", {m_addr, m_wdata}, {32'h2004, 32'h0000ABCD});
            end
        end
        check("t5_st_rvalid", {59'd0, dv5}, 64'b01000);
        check("t5_rdata_hold", {32'd0, rd2}, {32'd0, rd});
        step();
        idle_inputs();
        data_xact(1'b0, 4'hF, 32'h2004, 32'h0, g, r, rd);
        check("t5_readback", {32'd0, rd}, {32'd0, shadow_read(32'h2004)});

        // Reset during a busy load
        do_reset(1);
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h2010;
        @(negedge clk);
        check("t6_gnt", {63'd0, d_gnt}, 64'd1);
        step();
        reset = 1;
        idle_inputs();
        step();
        reset = 0;
        rst_rv = 0; rst_mreq = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            rst_rv = rst_rv | d_rvalid | if_rvalid;
            rst_mreq = rst_mreq | m_req;
            step();
        end
        check("t6_no_rvalid", {62'd0, rst_rv, rst_mreq}, 64'd0);
        data_xact(1'b0, 4'hF, 32'h2014, 32'h0, g, r, rd);
        check("t6_next_timing", {32'(g), 32'(r)}, {32'd0, 32'd3});
        check("t6_next_data", {32'd0, rd}, {32'd0, shadow_read(32'h2014)});

        // Randomized traffic against a transaction-level model
        do_reset(2);
        i_active = 0; i_granted = 0; i_got = 0; i_gap = 0; i_gnt_n = 0;
        d_active = 0; d_granted = 0; d_got = 0; d_gap = 0; d_gnt_n = 0; d_store = 0;
        i_exp = '0; d_exp = '0; d_model_rdata = '0; ref_last_d = 0;
        for (int n = 0; n < 800; n++) begin
            if (n > 0) step();
            if (i_active && i_got) begin
                i_active = 0; i_got = 0; if_req = 0; i_gap = $urandom_range(0, 2);
            end
            if (!i_active) begin
                if (i_gap > 0) i_gap--;
                else if ($urandom_range(0, 3) != 0) begin
                    i_active = 1; i_granted = 0; if_req = 1;
                    if_addr = 32'h100 + 32'(4 * $urandom_range(0, 63));
                    i_exp = shadow_read(if_addr);
                end
            end else if (i_granted && if_req && $urandom_range(0, 7) == 0) begin
                if_req = 0;
            end
            if (d_active && d_got) begin
                d_active = 0; d_got = 0; d_req = 0; d_gap = $urandom_range(0, 2);
            end
            if (!d_active) begin
                if (d_gap > 0) d_gap--;
                else if ($urandom_range(0, 3) != 0) begin
                    d_active = 1; d_granted = 0; d_req = 1;
                    d_store = ($urandom_range(0, 2) == 0);
                    d_we = d_store;
                    d_addr = 32'h2000 + 32'(4 * $urandom_range(0, 15));
                    d_be = 4'($urandom_range(1, 15));
                    d_wdata = $urandom;
                    if (d_store) shadow[d_addr] = merge(shadow_read(d_addr), d_be, d_wdata);
                    else         d_exp = shadow_read(d_addr);
                end
            end else if (d_granted && d_req && $urandom_range(0, 7) == 0) begin
                d_req = 0;
            end

            @(negedge clk);
            exp_iv = i_active && i_granted && (n == i_gnt_n + LAT + 1);
            exp_dv = d_active && d_granted && (n == d_gnt_n + LAT + 1);
            i_pend = if_req && i_active && !i_granted;
            d_pend = d_req && d_active && !d_granted;
            busy = (i_active && i_granted && !exp_iv) || (d_active && d_granted && !exp_dv);
            exp_any = !busy && (i_pend || d_pend);
`ifdef ARB_RR_EN
            exp_d = d_pend && (!i_pend || !ref_last_d);
            if (exp_any && i_pend && d_pend) ref_last_d = exp_d;
`else
            exp_d = d_pend;
`endif
            check("rnd_grant", {61'd0, m_req, if_gnt, d_gnt},
                  {61'd0, exp_any, exp_any && !exp_d, exp_any && exp_d});
            if (exp_any && !exp_d) begin i_granted = 1; i_gnt_n = n; end
            if (exp_any && exp_d)  begin d_granted = 1; d_gnt_n = n; end
            check("rnd_rvalid", {62'd0, if_rvalid, d_rvalid}, {62'd0, exp_iv, exp_dv});
            if (exp_iv) check("rnd_if_rdata", {32'd0, if_rdata}, {32'd0, i_exp});
            if (exp_dv) begin
                if (!d_store) d_model_rdata = d_exp;
                check("rnd_d_rdata", {32'd0, d_rdata}, {32'd0, d_model_rdata});
            end
            check("rnd_stall", {62'd0, stallF, stallM},
                  {62'd0, if_req && !exp_iv, d_req && !exp_dv});
            i_got = exp_iv;
            d_got = exp_dv;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
